// File: rtl/sram_fifo_ctrl_if.sv
// Stream and SRAM bus bundle for sram_fifo_ctrl: producer/consumer handshakes,
// occupancy, and the single-port SRAM initiator signals.
interface sram_fifo_ctrl_if #(
    parameter int unsigned DW = 152,
    parameter int unsigned AW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW+1:0] count;
    logic          sram_cen;
    logic          sram_wen;
    logic [AW-1:0] sram_a;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    modport master (
        input  in_valid, in_data, out_ready, sram_q,
        output in_ready, out_valid, out_data, count,
               sram_cen, sram_wen, sram_a, sram_d
    );

    modport slave (
        output in_valid, in_data, out_ready, sram_q,
        input  in_ready, out_valid, out_data, count,
               sram_cen, sram_wen, sram_a, sram_d
    );
endinterface

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready FIFO built on a single-port synchronous SRAM with a 2-entry output buffer.
// Optional macro WRITE_PRIORITY_EN: writes win arbitration instead of reads.
module sram_fifo_ctrl #(
    parameter int unsigned DW = 152,
    parameter int unsigned AW = 4
) (
    input logic            CLK,
    input logic            RESET_N,
    sram_fifo_ctrl_if.master bus
);
    localparam int unsigned DEPTH = 2 ** AW;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   mem_cnt;
    logic          rd_pend;
    logic [1:0]    ob_cnt;
    logic [DW-1:0] ob0;
    logic [DW-1:0] ob1;
    logic [AW+1:0] count_q;

    logic          pop;
    logic          rd_ok;
    logic          not_full;
    logic          read_issue;
    logic          write_issue;
    logic [2:0]    ob_load;

    always_comb begin
        // in_ready is held low while reset is asserted so the SRAM stays idle
        not_full = RESET_N && (mem_cnt != (AW+1)'(DEPTH));
        pop      = (ob_cnt != 2'd0) && bus.out_ready;
        ob_load  = {1'b0, ob_cnt} + {2'b00, rd_pend} - {2'b00, pop};
        rd_ok    = (mem_cnt != '0) && (ob_load < 3'd2);
`ifdef WRITE_PRIORITY_EN
        bus.in_ready = not_full;
        write_issue  = bus.in_valid && not_full;
        read_issue   = rd_ok && !write_issue;
`else
        bus.in_ready = not_full && !rd_ok;
        write_issue  = bus.in_valid && not_full && !rd_ok;
        read_issue   = rd_ok;
`endif
        bus.sram_cen = 1'b1;
        bus.sram_wen = 1'b1;
        bus.sram_a   = '0;
        if (read_issue) begin
            bus.sram_cen = 1'b0;
            bus.sram_a   = rd_ptr;
        end else if (write_issue) begin
            bus.sram_cen = 1'b0;
            bus.sram_wen = 1'b0;
            bus.sram_a   = wr_ptr;
        end
        bus.sram_d    = bus.in_data;
        bus.out_valid = (ob_cnt != 2'd0);
        bus.out_data  = ob0;
        bus.count     = count_q;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            mem_cnt <= '0;
            rd_pend <= 1'b0;
            ob_cnt  <= '0;
            count_q <= '0;
        end else begin
            if (write_issue) wr_ptr <= wr_ptr + 1'b1;
            if (read_issue)  rd_ptr <= rd_ptr + 1'b1;
            if (write_issue && !read_issue)      mem_cnt <= mem_cnt + 1'b1;
            else if (read_issue && !write_issue) mem_cnt <= mem_cnt - 1'b1;
            rd_pend <= read_issue;
            if (rd_pend && !pop)      ob_cnt <= ob_cnt + 1'b1;
            else if (!rd_pend && pop) ob_cnt <= ob_cnt - 1'b1;
            if (write_issue && !pop)      count_q <= count_q + 1'b1;
            else if (!write_issue && pop) count_q <= count_q - 1'b1;
        end
    end

    // Output buffer payload: ob0 is the head, ob1 only ever holds the second word.
    always_ff @(posedge CLK) begin
        if (rd_pend) begin
            if (pop) begin
                if (ob_cnt == 2'd2) begin
                    ob0 <= ob1;
                    ob1 <= bus.sram_q;
                end else begin
                    ob0 <= bus.sram_q;
                end
            end else if (ob_cnt == 2'd0) begin
                ob0 <= bus.sram_q;
            end else begin
                ob1 <= bus.sram_q;
            end
        end else if (pop) begin
            ob0 <= ob1;
        end
    end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Scoreboard bench for sram_fifo_ctrl with a behavioural 16-word SRAM.
// Define WRITE_PRIORITY_EN for both RTL and bench to exercise the write-priority build.
module tb_sram_fifo_ctrl;
    localparam int unsigned DW = 152;
    localparam int unsigned AW = 4;

    logic CLK;
    logic RESET_N;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned mode    = 1;
    logic [DW-1:0] sb[$];
    logic [AW-1:0] m_wr;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] mem [0:15];

    sram_fifo_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    sram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus.master)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!bus.sram_cen) begin
            if (!bus.sram_wen) mem[bus.sram_a] <= bus.sram_d;
            else               bus.sram_q <= mem[bus.sram_a];
        end
    end

    always begin
        @(posedge CLK);
        #1;
        case (mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: mid-cycle, record accepted words, check popped words and SRAM addresses.
    always @(negedge CLK) begin
        logic [DW-1:0] exp;
        if (!RESET_N) begin
            sb.delete();
            m_wr = '0;
            m_rd = '0;
        end else begin
            check("count", DW'(bus.count), DW'(sb.size()));
            check("count_max", DW'(bus.count > 6'd18), '0);
            if (!bus.sram_cen) begin
                if (!bus.sram_wen) begin
                    check("wr_addr", DW'(bus.sram_a), DW'(m_wr));
                    check("wr_data", bus.sram_d, bus.in_data);
                    check("wr_hs", DW'(bus.in_valid && bus.in_ready), DW'(1));
                    m_wr = m_wr + 1'b1;
                end else begin
                    check("rd_addr", DW'(bus.sram_a), DW'(m_rd));
                    m_rd = m_rd + 1'b1;
                end
            end
            if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", DW'(sb.size()), DW'(1));
                end else begin
                    exp = sb.pop_front();
                    check("out_data", bus.out_data, exp);
                end
            end
        end
    end

    task automatic send(input int unsigned n, input logic [DW-1:0] base);
        int unsigned sent = 0;
        int unsigned budget = 0;
        logic acc;
        while (sent < n && budget < 400) begin
            bus.in_valid = 1'b1;
            bus.in_data  = base + DW'(sent);
            @(negedge CLK);
            acc = bus.in_valid && bus.in_ready;
            @(posedge CLK);
            #1;
            if (acc) sent++;
            budget++;
        end
        bus.in_valid = 1'b0;
        check("send_done", DW'(sent), DW'(n));
    endtask

    task automatic wait_empty();
        int unsigned budget = 0;
        do begin
            @(negedge CLK);
            budget++;
        end while ((sb.size() != 0 || bus.out_valid) && budget < 400);
        check("drain", DW'(sb.size()), '0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [DW-1:0] pat;
        pat          = {19{8'hA5}};
        RESET_N      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b0;
        @(negedge CLK);
        check("rst_out_valid", DW'(bus.out_valid), '0);
        check("rst_count", DW'(bus.count), '0);
        check("rst_cen", DW'(bus.sram_cen), DW'(1));
        check("rst_wen", DW'(bus.sram_wen), DW'(1));
        check("rst_a", DW'(bus.sram_a), '0);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Single word latency
        bus.in_valid = 1'b1;
        bus.in_data  = pat;
        @(negedge CLK);
        check("t1_c0_cen", DW'(bus.sram_cen), '0);
        check("t1_c0_wen", DW'(bus.sram_wen), '0);
        check("t1_c0_a", DW'(bus.sram_a), '0);
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        @(negedge CLK);
        check("t1_c1_cen", DW'(bus.sram_cen), '0);
        check("t1_c1_wen", DW'(bus.sram_wen), DW'(1));
        check("t1_c1_cnt", DW'(bus.count), DW'(1));
        @(negedge CLK);
        check("t1_c2_valid", DW'(bus.out_valid), '0);
        @(negedge CLK);
        check("t1_c3_valid", DW'(bus.out_valid), DW'(1));
        check("t1_c3_data", bus.out_data, pat);
        @(posedge CLK);
        #1;
        check("t1_cnt_after", DW'(bus.count), '0);

        // Fill to 18 with consumer stalled
        mode = 0;
        @(posedge CLK);
        #1;
        send(18, '0);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(18);
        repeat (3) begin
            @(negedge CLK);
            check("full_ready", DW'(bus.in_ready), '0);
            check("full_count", DW'(bus.count), DW'(18));
            check("full_cen", DW'(bus.sram_cen), DW'(1));
        end
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        mode = 1;
        wait_empty();

        // Pointer wrap with random back-pressure
        mode = 2;
        send(40, DW'(100));
        mode = 1;
        wait_empty();

        // Both sides always active
        send(30, DW'(200));
        wait_empty();

        // Asynchronous reset mid-stream at count 7
        mode = 0;
        @(posedge CLK);
        #1;
        send(7, DW'(300));
        @(negedge CLK);
        check("pre_rst_count", DW'(bus.count), DW'(7));
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_valid", DW'(bus.out_valid), '0);
        check("arst_count", DW'(bus.count), '0);
        check("arst_cen", DW'(bus.sram_cen), DW'(1));
        repeat (2) @(negedge CLK);
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        mode = 1;
        @(posedge CLK);
        #1;
        send(1, DW'(32'h777));
        wait_empty();

`ifdef WRITE_PRIORITY_EN
        mode = 0;
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b1;
        for (int unsigned k = 0; k < 16; k++) begin
            bus.in_data = DW'(500 + k);
            @(negedge CLK);
            check("wp_wen", DW'(bus.sram_wen), '0);
            check("wp_a", DW'(bus.sram_a), DW'(k));
            @(posedge CLK);
            #1;
        end
        @(negedge CLK);
        check("wp_ready_low", DW'(bus.in_ready), '0);
        check("wp_rd_cen", DW'(bus.sram_cen), '0);
        check("wp_rd_wen", DW'(bus.sram_wen), DW'(1));
        check("wp_rd_a", DW'(bus.sram_a), '0);
        @(posedge CLK);
        #1;
        bus.in_valid = 1'b0;
        mode = 1;
        wait_empty();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
